// File: rtl/fib_bcd_conv.sv
// rtl/fib_bcd_conv.sv - binary to packed BCD converter for Fibonacci terms (double-dabble, 1-entry pending buffer)
// Define FIB_SEQ_CHECK_EN to add the seq_err output and the Fibonacci sequence checker.
module fib_bcd_conv #(
    parameter int DATA_W = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_valid,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  overflow,
    input  logic                  clear_ovf
`ifdef FIB_SEQ_CHECK_EN
    ,
    output logic                  seq_err
`endif
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t                r_state;
    logic [DATA_W-1:0]     r_bin;
    logic [4*DIGITS-1:0]   r_acc;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_W-1:0]     r_pend_data;
    logic                  r_pend_full;

    logic                  w_hs;
    logic                  w_direct;
    logic                  w_drain;
    logic                  w_to_pend;
    logic                  w_drop;
    logic [4*DIGITS-1:0]   w_adj;
    logic [4*DIGITS-1:0]   w_acc_nxt;

    assign w_hs      = (r_state == S_HOLD) && out_valid && out_ready;
    assign w_drain   = w_hs && r_pend_full;
    // A term goes straight into the engine only when the engine is free and nothing is queued ahead of it.
    assign w_direct  = in_valid && ((r_state == S_IDLE) || (w_hs && !r_pend_full));
    assign w_to_pend = in_valid && !w_direct && (!r_pend_full || w_drain);
    assign w_drop    = in_valid && !w_direct && r_pend_full && !w_drain;

    always_comb begin
        w_adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_adj[4*i +: 4] = (r_acc[4*i +: 4] >= 4'd5) ? (r_acc[4*i +: 4] + 4'd3) : r_acc[4*i +: 4];
        end
    end

    assign w_acc_nxt = {w_adj[4*DIGITS-2:0], r_bin[DATA_W-1]};
    assign busy      = (r_state != S_IDLE) || r_pend_full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_bin       <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_pend_data <= '0;
            r_pend_full <= 1'b0;
            out_bcd     <= '0;
            out_valid   <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_bin   <= in_data;
                        r_acc   <= '0;
                        r_cnt   <= CNT_W'(DATA_W);
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_acc <= w_acc_nxt;
                    r_bin <= r_bin << 1;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state   <= S_HOLD;
                        out_bcd   <= w_acc_nxt;
                        out_valid <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (w_hs) begin
                        out_valid <= 1'b0;
                        if (r_pend_full) begin
                            r_bin   <= r_pend_data;
                            r_acc   <= '0;
                            r_cnt   <= CNT_W'(DATA_W);
                            r_state <= S_SHIFT;
                        end else if (in_valid) begin
                            r_bin   <= in_data;
                            r_acc   <= '0;
                            r_cnt   <= CNT_W'(DATA_W);
                            r_state <= S_SHIFT;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_to_pend) begin
                r_pend_data <= in_data;
                r_pend_full <= 1'b1;
            end else if (w_drain) begin
                r_pend_full <= 1'b0;
            end

            if (w_drop)
                overflow <= 1'b1;
            else if (clear_ovf)
                overflow <= 1'b0;
        end
    end

`ifdef FIB_SEQ_CHECK_EN
    logic [DATA_W-1:0] r_p0;
    logic [DATA_W-1:0] r_p1;
    logic [1:0]        r_hist;
    logic [DATA_W-1:0] w_sum;
    logic              w_accept;
    logic              w_mismatch;

    // Terms are checked in arrival order, which is also the order they are converted.
    assign w_sum      = r_p0 + r_p1;
    assign w_accept   = in_valid && !w_drop;
    assign w_mismatch = w_accept && (r_hist == 2'd2) && (in_data != w_sum);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_p0    <= '0;
            r_p1    <= '0;
            r_hist  <= 2'd0;
            seq_err <= 1'b0;
        end else begin
            if (w_drop) begin
                r_hist <= 2'd0;
            end else if (w_accept) begin
                r_p0   <= r_p1;
                r_p1   <= in_data;
                r_hist <= (r_hist == 2'd2) ? 2'd2 : r_hist + 2'd1;
            end

            if (w_mismatch)
                seq_err <= 1'b1;
            else if (clear_ovf)
                seq_err <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_fib_bcd_conv.sv
// tb/tb_fib_bcd_conv.sv - self-checking bench for fib_bcd_conv (directed + randomized, arithmetic BCD model)
module tb_fib_bcd_conv;

    logic        clk;
    logic        reset;
    logic [15:0] in_data;
    logic        in_valid;
    logic [19:0] out_bcd;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        overflow;
    logic        clear_ovf;
`ifdef FIB_SEQ_CHECK_EN
    logic        seq_err;
`endif

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    fib_bcd_conv #(.DATA_W(16), .DIGITS(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_bcd   (out_bcd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .overflow  (overflow),
        .clear_ovf (clear_ovf)
`ifdef FIB_SEQ_CHECK_EN
        ,
        .seq_err   (seq_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] bcd_of(input int v);
        logic [19:0] r;
        int p;
        r = '0;
        p = 1;
        for (int k = 0; k < 5; k++) begin
            r[4*k +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v);
        in_data  = 16'(v);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic convert_check(input int v);
        exp_q.push_back(v);
        send(v);
        repeat (15) tick();
        chk("lat_early", 32'(out_valid), 32'd0);
        tick();
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_bcd", 32'(out_bcd), 32'(bcd_of(v)));
        tick();
        chk("post_hs_valid", 32'(out_valid), 32'd0);
        chk("post_hs_idle", 32'(busy), 32'd0);
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk(tag, 32'(out_valid), 32'd1);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 32'(exp_q.size()), 32'd0);
        tick();
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    // Every handshake must match the oldest outstanding term the bench expects.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 32'(out_bcd), 32'hFFFFFFFF);
            end else begin
                chk("out_order", 32'(out_bcd), 32'(bcd_of(exp_q.pop_front())));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int b;
        reset     = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        clear_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_bcd", 32'(out_bcd), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        reset = 1'b0;
        tick();

        // Reset mid-conversion: outputs clear immediately, no late output.
        send(1234);
        repeat (5) tick();
        chk("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_bcd", 32'(out_bcd), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_ovf", 32'(overflow), 32'd0);
        tick();
        reset = 1'b0;
        repeat (30) tick();
        chk("mrst_no_out", 32'(out_valid), 32'd0);

        convert_check(6765);
        convert_check(65535);
        convert_check(0);
        for (int i = 0; i < 8; i++) convert_check(int'($urandom_range(0, 65535)));

        // Held output, pending term, dropped term, sticky overflow.
        out_ready = 1'b0;
        exp_q.push_back(8);
        send(8);
        repeat (4) tick();
        exp_q.push_back(13);
        send(13);
        repeat (19) tick();
        send(21);
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_bcd", 32'(out_bcd), 32'h00008);
        chk("drop_ovf", 32'(overflow), 32'd1);
        chk("drop_busy", 32'(busy), 32'd1);
        repeat (3) tick();
        chk("hold_stable", 32'(out_bcd), 32'h00008);
        out_ready = 1'b1;
        drain("drain_8_13");
        chk("ovf_sticky", 32'(overflow), 32'd1);
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        chk("ovf_clear", 32'(overflow), 32'd0);

        // Pending drains and refills in the same cycle: no overflow.
        out_ready = 1'b0;
        exp_q.push_back(34);
        send(34);
        repeat (2) tick();
        exp_q.push_back(13);
        send(13);
        wait_valid("wait_34");
        out_ready = 1'b1;
        exp_q.push_back(21);
        send(21);
        chk("refill_ovf", 32'(overflow), 32'd0);
        chk("refill_busy", 32'(busy), 32'd1);
        drain("drain_refill");
        chk("refill_ovf_end", 32'(overflow), 32'd0);

        // Random back-to-back pairs with a stalled consumer.
        for (int i = 0; i < 6; i++) begin
            a = int'($urandom_range(0, 65535));
            b = int'($urandom_range(0, 65535));
            out_ready = 1'b0;
            exp_q.push_back(a);
            send(a);
            repeat ($urandom_range(0, 10)) tick();
            exp_q.push_back(b);
            send(b);
            repeat ($urandom_range(0, 30)) tick();
            out_ready = 1'b1;
            drain("drain_rand");
            chk("rand_ovf", 32'(overflow), 32'd0);
        end

`ifdef FIB_SEQ_CHECK_EN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        convert_check(0);
        convert_check(1);
        convert_check(1);
        convert_check(2);
        convert_check(3);
        convert_check(5);
        chk("seq_ok", 32'(seq_err), 32'd0);
        convert_check(9);
        chk("seq_bad", 32'(seq_err), 32'd1);
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        chk("seq_clear", 32'(seq_err), 32'd0);
`endif

        repeat (5) tick();
        chk("final_q", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
